// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared config for the byte-serial memory controller
//
// Purpose: state encodings, mem_size codes, address width, RAM byte width,
//          the IO address mask and the size-to-byte-count helper used by
//          mem_ctrl.
// Ports:   none (package).
package mem_ctrl_pkg;

  localparam int AddrLen  = 32;
  localparam int ByteW    = 8;
  localparam int StateLen = 3;

  // Stores whose address has both of these bits set target the UART buffer.
  localparam logic [AddrLen-1:0] IoAddrMask = 32'h0003_0000;

  localparam logic [1:0] Size_Byte = 2'b00;
  localparam logic [1:0] Size_Half = 2'b01;
  localparam logic [1:0] Size_Word = 2'b10;

  typedef enum logic [StateLen-1:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Bytes moved for a load/store; the unused code 11 behaves as a word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      Size_Byte: n = 3'd1;
      Size_Half: n = 3'd2;
      default:   n = 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller shared by fetch and load/store
//
// Purpose: arbitrates instruction fetch and load/store requests onto an
//          8-bit synchronous RAM, one byte per cycle, little-endian.
// Ports:
//   clk, rst                 clock, async active-low reset
//   if_req/if_addr/if_flush  fetch request, byte address, redirect
//   if_done/if_inst          fetch completion pulse and fetched word
//   mem_req/mem_we/mem_addr/mem_size/mem_wdata   load/store request
//   mem_done/mem_rdata       load/store completion pulse, zero-extended data
//   ram_din/ram_dout/ram_a/ram_wr                RAM byte port
//   io_buffer_full           UART buffer full
//   busy                     controller not idle
// Build option: MEM_CTRL_IO_STALL_EN holds IO-region stores while
//               io_buffer_full is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [AddrLen-1:0] if_addr,
  input  logic               if_flush,
  output logic               if_done,
  output logic [31:0]        if_inst,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [AddrLen-1:0] mem_addr,
  input  logic [1:0]         mem_size,
  input  logic [31:0]        mem_wdata,
  output logic               mem_done,
  output logic [31:0]        mem_rdata,
  input  logic [ByteW-1:0]   ram_din,
  output logic [ByteW-1:0]   ram_dout,
  output logic [AddrLen-1:0] ram_a,
  output logic               ram_wr,
  input  logic               io_buffer_full,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;      // cycles elapsed in the active phase
  logic [2:0]         n_q, n_d;          // bytes in this transaction
  logic [AddrLen-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        asm_q, asm_d;      // read assembly shift register

  logic [AddrLen-1:0] ram_a_q, ram_a_d;
  logic [ByteW-1:0]   ram_dout_q, ram_dout_d;
  logic               ram_wr_q, ram_wr_d;
  logic               if_done_q, if_done_d;
  logic [31:0]        if_inst_q, if_inst_d;
  logic               mem_done_q, mem_done_d;
  logic [31:0]        mem_rdata_q, mem_rdata_d;

  logic               io_stall;
  logic [2:0]         next_idx;
  logic [31:0]        wshift;
  logic [31:0]        rd_word;

`ifdef MEM_CTRL_IO_STALL_EN
  // A stalled IO store keeps the whole controller idle, fetches included.
  assign io_stall = mem_req && mem_we && io_buffer_full &&
                    ((mem_addr & IoAddrMask) == IoAddrMask);
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign io_stall = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    ram_a_d     = '0;
    ram_dout_d  = '0;
    ram_wr_d    = 1'b0;
    if_done_d   = 1'b0;
    if_inst_d   = if_inst_q;
    mem_done_d  = 1'b0;
    mem_rdata_d = mem_rdata_q;
    next_idx    = cnt_q + 3'd1;
    wshift      = '0;
    rd_word     = '0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        asm_d = '0;
        if (mem_req && !io_stall) begin
          n_d     = size_to_n(mem_size);
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          ram_a_d = mem_addr;
          if (mem_we) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req && !if_flush && !io_stall) begin
          n_d     = 3'd4;
          addr_d  = if_addr;
          ram_a_d = if_addr;
          state_d = IF_RD;
        end
      end

      IF_RD, MEM_RD: begin
        if (state_q == IF_RD && if_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = next_idx;
          if (next_idx < n_q) begin
            ram_a_d = addr_q + {{(AddrLen-3){1'b0}}, next_idx};
          end
          // ram_din carries the byte addressed one cycle earlier, so
          // capture starts one cycle after the first address.
          if (cnt_q != 3'd0) begin
            asm_d = {ram_din, asm_q[31:8]};
          end
          if (cnt_q == n_q) begin
            state_d = DONE;
            cnt_d   = '0;
            // Bytes enter from the top; slide them down so unread bytes are 0.
            rd_word = asm_d >> {3'd4 - n_q, 3'b000};
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = rd_word;
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = rd_word;
            end
          end
        end
      end

      MEM_WR: begin
        if (next_idx < n_q) begin
          cnt_d      = next_idx;
          wshift     = wdata_q >> {next_idx[1:0], 3'b000};
          ram_a_d    = addr_q + {{(AddrLen-3){1'b0}}, next_idx};
          ram_wr_d   = 1'b1;
          ram_dout_d = wshift[7:0];
        end else begin
          state_d    = DONE;
          cnt_d      = '0;
          mem_done_d = 1'b1;
        end
      end

      DONE: begin
        // Requesters still hold req during this cycle; ignore them.
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      if_inst_q   <= if_inst_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_done;
  logic [31:0] if_inst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic [31:0] mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic        io_buffer_full;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .io_buffer_full(io_buffer_full), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: preloaded contents plus a write overlay.
  bit [7:0] wr_mem   [0:16383];
  bit       wr_valid [0:16383];

  function automatic logic [13:0] ridx(input logic [31:0] a);
    return {a[17:16], a[11:0]};
  endfunction

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;  32'h101: return 8'h05;
      32'h102: return 8'h50;  32'h103: return 8'h00;
      32'h104: return 8'h93;  32'h105: return 8'h02;
      32'h106: return 8'h10;  32'h107: return 8'h00;
      32'h200: return 8'h78;  32'h201: return 8'h56;
      32'h202: return 8'h34;  32'h203: return 8'h12;
      32'h302: return 8'hAA;
      32'hFFFF_FFFE: return 8'h11;
      32'hFFFF_FFFF: return 8'h22;
      32'h0: return 8'h33;
      32'h1: return 8'h44;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return wr_valid[ridx(a)] ? wr_mem[ridx(a)] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (ram_wr) begin
      wr_mem[ridx(ram_a)]   <= ram_dout;
      wr_valid[ridx(ram_a)] <= 1'b1;
    end
    ram_din <= mem_rd(ram_a);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] exp, input int exp_cyc);
    int got_cyc;
    logic [31:0] d;
    got_cyc = 0;
    d = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = a; mem_size = sz;
    for (int c = 1; c <= 12; c++) begin
      nxt();
      if (mem_done && got_cyc == 0) begin
        got_cyc = c;
        d = mem_rdata;
        mem_req = 1'b0;
      end
    end
    mem_req = 1'b0;
    chk({tag, "_cyc"}, got_cyc, exp_cyc);
    chk({tag, "_data"}, d, exp);
  endtask

  initial begin : stim
    int md, idn, seen, dn_cnt;
    logic [31:0] rd;
    logic [31:0] inst;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_size = 2'b00;
    mem_wdata = '0; io_buffer_full = 1'b0;

    // Reset state
    nxt(); nxt();
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_wr", 32'(ram_wr), 0);
    chk("rst_ram_dout", 32'(ram_dout), 0);
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_mem_done", 32'(mem_done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_if_inst", if_inst, 0);
    chk("rst_mem_rdata", mem_rdata, 0);

    // Fetch sampled on the first edge after reset release
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100;
    for (int k = 1; k <= 4; k++) begin
      nxt();
      chk($sformatf("fetch_a%0d", k), ram_a, 32'h100 + 32'(k - 1));
      if (k == 1) begin
        chk("fetch_wr", 32'(ram_wr), 0);
        chk("fetch_busy", 32'(busy), 1);
      end
    end
    nxt();
    chk("fetch_done_t5", 32'(if_done), 0);
    chk("fetch_a_t5", ram_a, 0);
    nxt();
    chk("fetch_done_t6", 32'(if_done), 1);
    chk("fetch_inst", if_inst, 32'h0050_0513);
    if_req = 1'b0;
    nxt();
    chk("fetch_idle_t7", 32'(busy), 0);
    chk("fetch_done_t7", 32'(if_done), 0);

    // Arbitration: load wins, fetch follows after DONE
    md = 0; idn = 0; rd = '0; inst = '0;
    if_req = 1'b1; if_addr = 32'h104;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_size = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      nxt();
      if (c == 1) chk("arb_first_a", ram_a, 32'h200);
      if (c == 8) chk("arb_fetch_a", ram_a, 32'h104);
      if (mem_done && md == 0) begin md = c; rd = mem_rdata; mem_req = 1'b0; end
      if (if_done && idn == 0) begin idn = c; inst = if_inst; if_req = 1'b0; end
    end
    if_req = 1'b0; mem_req = 1'b0;
    chk("arb_mem_cyc", md, 6);
    chk("arb_mem_data", rd, 32'h1234_5678);
    chk("arb_if_cyc", idn, 13);
    chk("arb_if_inst", inst, 32'h0010_0293);

    // Store half
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_size = 2'b01;
    mem_wdata = 32'hDEAD_BEEF;
    nxt();
    chk("sth_wr1", 32'(ram_wr), 1);
    chk("sth_a1", ram_a, 32'h300);
    chk("sth_d1", 32'(ram_dout), 32'hEF);
    nxt();
    chk("sth_wr2", 32'(ram_wr), 1);
    chk("sth_a2", ram_a, 32'h301);
    chk("sth_d2", 32'(ram_dout), 32'hBE);
    nxt();
    chk("sth_wr3", 32'(ram_wr), 0);
    chk("sth_done", 32'(mem_done), 1);
    chk("sth_rdata_hold", mem_rdata, 32'h1234_5678);
    mem_req = 1'b0; mem_we = 1'b0;
    nxt();
    chk("sth_m300", 32'(mem_rd(32'h300)), 32'hEF);
    chk("sth_m301", 32'(mem_rd(32'h301)), 32'hBE);
    chk("sth_m302", 32'(mem_rd(32'h302)), 32'hAA);

    // Loads of each size, zero-extended; size 11 acts as word
    do_load("ld_b", 32'h301, 2'b00, 32'h0000_00BE, 3);
    do_load("ld_h", 32'h300, 2'b01, 32'h0000_BEEF, 4);
    do_load("ld_w11", 32'h200, 2'b11, 32'h1234_5678, 6);

    // Flush mid-fetch with a load waiting
    seen = 0;
    if_req = 1'b1; if_addr = 32'h100;
    nxt(); nxt(); nxt();
    chk("fl_a_t3", ram_a, 32'h102);
    if_flush = 1'b1; if_req = 1'b0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h203; mem_size = 2'b00;
    nxt();
    chk("fl_busy_t4", 32'(busy), 0);
    chk("fl_a_t4", ram_a, 0);
    if (if_done) seen++;
    if_flush = 1'b0;
    nxt();
    chk("fl_ld_a_t5", ram_a, 32'h203);
    chk("fl_busy_t5", 32'(busy), 1);
    if (if_done) seen++;
    nxt();
    if (if_done) seen++;
    nxt();
    if (if_done) seen++;
    chk("fl_ld_done_t7", 32'(mem_done), 1);
    chk("fl_ld_data", mem_rdata, 32'h0000_0012);
    mem_req = 1'b0;
    chk("fl_no_if_done", seen, 0);
    chk("fl_inst_hold", if_inst, 32'h0010_0293);
    nxt();

    // Flush in IDLE blocks acceptance that cycle only
    if_req = 1'b1; if_addr = 32'h104; if_flush = 1'b1;
    nxt();
    chk("fli_busy", 32'(busy), 0);
    if_flush = 1'b0;
    nxt();
    chk("fli_a", ram_a, 32'h104);
    seen = 0;
    for (int c = 3; c <= 15; c++) begin
      nxt();
      if (if_done && seen == 0) begin seen = c; if_req = 1'b0; end
    end
    if_req = 1'b0;
    chk("fli_done_cyc", seen, 7);
    chk("fli_inst", if_inst, 32'h0010_0293);

    // Address wrap-around
    md = 0; rd = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'hFFFF_FFFE; mem_size = 2'b10;
    for (int c = 1; c <= 10; c++) begin
      nxt();
      if (c == 2) chk("wrap_a2", ram_a, 32'hFFFF_FFFF);
      if (c == 3) chk("wrap_a3", ram_a, 32'h0);
      if (mem_done && md == 0) begin md = c; rd = mem_rdata; mem_req = 1'b0; end
    end
    mem_req = 1'b0;
    chk("wrap_cyc", md, 6);
    chk("wrap_data", rd, 32'h4433_2211);

    // Reset in the middle of a word store
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_size = 2'b10;
    mem_wdata = 32'h1122_3344;
    nxt();
    chk("rs_wr_t1", 32'(ram_wr), 1);
    nxt();
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    #1;
    chk("rs_wr_async", 32'(ram_wr), 0);
    chk("rs_a_async", ram_a, 0);
    chk("rs_busy_async", 32'(busy), 0);
    nxt();
    rst = 1'b1;
    dn_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      nxt();
      if (mem_done || busy) dn_cnt++;
    end
    chk("rs_no_done", dn_cnt, 0);
    chk("rs_m400", 32'(mem_rd(32'h400)), 32'h44);
    chk("rs_m401", 32'(mem_rd(32'h401)), 32'h00);

    // IO write throttle
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0003_0000; mem_size = 2'b00;
    mem_wdata = 32'h0000_005A;
`ifdef MEM_CTRL_IO_STALL_EN
    for (int c = 1; c <= 5; c++) begin
      nxt();
      chk($sformatf("io_hold_wr%0d", c), 32'(ram_wr), 0);
      chk($sformatf("io_hold_busy%0d", c), 32'(busy), 0);
    end
    io_buffer_full = 1'b0;
    nxt();
    chk("io_go_wr", 32'(ram_wr), 1);
    chk("io_go_a", ram_a, 32'h0003_0000);
    chk("io_go_d", 32'(ram_dout), 32'h5A);
    nxt();
    chk("io_go_done", 32'(mem_done), 1);
    mem_req = 1'b0;
    nxt();
    io_buffer_full = 1'b1;
    mem_req = 1'b1; mem_addr = 32'h0002_0000; mem_wdata = 32'h66;
    nxt();
    chk("io_other_wr", 32'(ram_wr), 1);
    chk("io_other_a", ram_a, 32'h0002_0000);
    nxt();
    chk("io_other_done", 32'(mem_done), 1);
    mem_req = 1'b0;
`else
    nxt();
    chk("io_ign_wr", 32'(ram_wr), 1);
    chk("io_ign_a", ram_a, 32'h0003_0000);
    chk("io_ign_d", 32'(ram_dout), 32'h5A);
    nxt();
    chk("io_ign_done", 32'(mem_done), 1);
    mem_req = 1'b0;
`endif
    io_buffer_full = 1'b0; mem_we = 1'b0;
    nxt(); nxt();
    chk("end_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
